// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the spare read-port arbiter.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;
  localparam logic [4:0] REG_XZR_IDX = 5'd31;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search starting at rr_ptr, plus the pointer register.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] winner
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N-1);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] idx;

  // Walk N positions from rr_ptr; wrap is explicit so non-power-of-two N works.
  always_comb begin
    gnt    = '0;
    winner = '0;
    idx    = rr_ptr;
    if (en && !reset) begin
      for (int i = 0; i < N; i++) begin
        if (gnt == '0 && req[idx]) begin
          gnt[idx] = 1'b1;
          winner   = idx;
        end
        idx = (idx == LAST) ? '0 : idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr <= '0;
    else if (|gnt)
      rr_ptr <= (winner == LAST) ? '0 : winner + IW'(1);
  end
endmodule

// File: rtl/regfile_rdport_arbiter.sv
// Shares the spare regfile read port among NUM_REQ readers; one-cycle response.
// Optional REGFILE_ARB_XZR_EN: reads of index 31 return zero (XZR).
module regfile_rdport_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [ADDR_W-1:0]               rd_sel,
  input  logic [DATA_W-1:0]               rd_data,
  input  logic                            resp_stall,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [DATA_W-1:0]               resp_data
);
  logic [$clog2(NUM_REQ)-1:0] winner;
  logic [ADDR_W-1:0]          sel_q;
  logic [DATA_W-1:0]          cap_data;
  logic                       any_gnt;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (~resp_stall),
    .req    (req),
    .gnt    (gnt),
    .winner (winner)
  );

  assign any_gnt = |gnt;
  // Idle and stalled cycles keep the last select so the mux does not toggle.
  assign rd_sel  = any_gnt ? req_addr[winner] : sel_q;

`ifdef REGFILE_ARB_XZR_EN
  assign cap_data = (req_addr[winner] == ADDR_W'(REG_XZR_IDX)) ? '0 : rd_data;
`else
  assign cap_data = rd_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q      <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else if (!resp_stall) begin
      resp_valid <= gnt;
      if (any_gnt) begin
        sel_q     <= req_addr[winner];
        resp_data <= cap_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_rdport_arbiter.sv
// Scoreboard bench: expected responses queued at grant time, checked a cycle later.
module tb_regfile_rdport_arbiter;
  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req;
  logic [3:0][4:0]  req_addr;
  logic [3:0]       gnt;
  logic [4:0]       rd_sel;
  logic [63:0]      rd_data;
  logic             resp_stall;
  logic [3:0]       resp_valid;
  logic [63:0]      resp_data;

  logic [63:0] regs [32];

  typedef struct {
    logic [3:0]  v;
    logic [63:0] d;
  } resp_t;
  resp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  int          ptr_m;
  logic [4:0]  sel_m;
  logic [3:0]  last_v;
  logic [63:0] last_d;

  always #5 clk = ~clk;
  assign rd_data = regs[rd_sel];

  regfile_rdport_arbiter #(.NUM_REQ(4), .DATA_W(64), .ADDR_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
    .gnt        (gnt),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .resp_stall (resp_stall),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_data(input logic [4:0] a);
`ifdef REGFILE_ARB_XZR_EN
    if (a == 5'd31) return 64'h0;
`endif
    return regs[a];
  endfunction

  task automatic model_reset();
    ptr_m  = 0;
    sel_m  = '0;
    last_v = '0;
    last_d = '0;
    sb.delete();
  endtask

  // Called just after a rising edge; drives one cycle and checks it.
  task automatic step(input logic [3:0] r, input logic s);
    logic [3:0] eg;
    int         w;
    resp_t      e, got;
    req = r;
    resp_stall = s;
    #2;
    eg = '0;
    w  = -1;
    if (!s) begin
      for (int i = 0; i < 4; i++) begin
        int k;
        k = (ptr_m + i) % 4;
        if (w < 0 && r[k]) w = k;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", {60'h0, gnt}, {60'h0, eg});
    if (w >= 0) begin
      chk("rd_sel", {59'h0, rd_sel}, {59'h0, req_addr[w]});
      sel_m  = req_addr[w];
      last_d = exp_data(req_addr[w]);
      ptr_m  = (w + 1) % 4;
    end else begin
      chk("rd_sel_hold", {59'h0, rd_sel}, {59'h0, sel_m});
    end
    if (!s) last_v = eg;
    e.v = last_v;
    e.d = last_d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'h0, 64'h1);
    end else begin
      got = sb.pop_front();
      chk("resp_valid", {60'h0, resp_valid}, {60'h0, got.v});
      chk("resp_data", resp_data, got.d);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    regs[31] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_addr[0] = 5'd3;
    req_addr[1] = 5'd5;
    req_addr[2] = 5'd7;
    req_addr[3] = 5'd12;
    req = 4'b1111;
    resp_stall = 1'b0;
    reset = 1'b1;
    model_reset();
    #2;
    chk("rst_gnt", {60'h0, gnt}, 64'h0);
    chk("rst_rd_sel", {59'h0, rd_sel}, 64'h0);
    chk("rst_valid", {60'h0, resp_valid}, 64'h0);
    chk("rst_data", resp_data, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // full contention: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b0);
    // single read of x7 by requester 2
    step(4'b0100, 1'b0);
    // wrap: ptr now 3, 1001 -> 3 then 0
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);
    // stall with a response pending
    step(4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b1);
    step(4'b0010, 1'b0);
    // idle: no grant, select holds, valid clears
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    // x31 read by requester 0
    req_addr[0] = 5'd31;
    step(4'b0001, 1'b0);
    req_addr[0] = 5'd3;

    // random traffic
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) req_addr[k] = 5'($urandom_range(0, 31));
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end

    // reset mid-traffic
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    req = 4'b1111;
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", {60'h0, gnt}, 64'h0);
    chk("mid_rst_valid", {60'h0, resp_valid}, 64'h0);
    chk("mid_rst_data", resp_data, 64'h0);
    chk("mid_rst_rd_sel", {59'h0, rd_sel}, 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
